// File: rtl/dot_scan_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dot_pkg
//  Description : Shared definitions for the dot-matrix frame buffer / scan
//                block: matrix geometry, arbiter state encoding and the
//                row index to active-low one-hot row-select mapping.
//  Revision    : 1.0  initial release
// ============================================================================
package dot_pkg;

    localparam int DOT_ROWS = 8;
    localparam int DOT_COLS = 16;
    localparam int ROW_W    = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_A = 2'd1,
        GNT_B = 2'd2
    } arb_state_e;

    // Row 0 is wired to the top pin (bit 7), row 7 to bit 0; pins are active low.
    function automatic logic [DOT_ROWS-1:0] row_sel(input logic [ROW_W-1:0] idx);
        return ~(8'h80 >> idx);
    endfunction

endpackage
`default_nettype wire

// File: rtl/dot_scan_arbiter_rr_arb.sv
`default_nettype none
// ============================================================================
//  Module      : dot_rr_arb
//  Description : Two-way round-robin grant FSM. A grant lasts exactly one
//                cycle and is always followed by an idle cycle, so at most
//                one write is committed every two cycles.
//  Ports       : clk, rst      - clock, synchronous active-high reset
//                req_a, req_b  - write requests
//                gnt_a, gnt_b  - one-cycle grant/commit pulses (exclusive)
//                sel           - 0: A owns the commit, 1: B owns the commit
//  Revision    : 1.0  initial release
// ============================================================================
module dot_rr_arb
    import dot_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic req_a,
    input  logic req_b,
    output logic gnt_a,
    output logic gnt_b,
    output logic sel
);

    localparam logic [1:0] c_ST_IDLE  = IDLE;
    localparam logic [1:0] c_ST_GNT_A = GNT_A;
    localparam logic [1:0] c_ST_GNT_B = GNT_B;

    logic [1:0] r_state;
    logic [1:0] w_state_nxt;
    logic       r_prio_b;   // set when B was not granted last, so B wins a tie

    always_comb begin
        w_state_nxt = c_ST_IDLE;
        if (r_state == c_ST_IDLE) begin
            if (req_a && req_b) begin
                w_state_nxt = r_prio_b ? c_ST_GNT_B : c_ST_GNT_A;
            end else if (req_a) begin
                w_state_nxt = c_ST_GNT_A;
            end else if (req_b) begin
                w_state_nxt = c_ST_GNT_B;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_ST_IDLE;
            r_prio_b <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == c_ST_GNT_A) begin
                r_prio_b <= 1'b1;
            end else if (r_state == c_ST_GNT_B) begin
                r_prio_b <= 1'b0;
            end
        end
    end

    assign gnt_a = (r_state == c_ST_GNT_A);
    assign gnt_b = (r_state == c_ST_GNT_B);
    assign sel   = gnt_b;

endmodule
`default_nettype wire

// File: rtl/dot_scan_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : dot_scan_arbiter
//  Description : Owns the 8x16 LED frame buffer. Two row writers (A: button
//                shift engine, B: pattern loader) share the buffer through a
//                round-robin arbiter; a row-scan sequencer drives the matrix
//                pins one row per SCAN_DIV clocks.
//  Parameters  : SCAN_DIV  - clocks per displayed row (4 .. 2^20)
//                BLANK_CYC - blanking clocks at each row start (< SCAN_DIV)
//  Macro       : DOT_BLANK_EN - when defined, pins are blanked for BLANK_CYC
//                clocks after every row load; otherwise BLANK_CYC is unused.
//  Ports       : clk, rst             - clock, synchronous active-high reset
//                req_x/row_x/data_x   - requester x write request/row/data
//                gnt_x                - one-cycle commit pulse to requester x
//                dot_row              - active-low one-hot row select
//                dot_col              - active-high column drive
//                frame_start          - pulse coincident with the row-0 load
//  Revision    : 1.0  initial release
// ============================================================================
module dot_scan_arbiter
    import dot_pkg::*;
#(
    parameter int SCAN_DIV  = 5000,
    parameter int BLANK_CYC = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_a,
    input  logic [ROW_W-1:0]    row_a,
    input  logic [DOT_COLS-1:0] data_a,
    output logic                gnt_a,
    input  logic                req_b,
    input  logic [ROW_W-1:0]    row_b,
    input  logic [DOT_COLS-1:0] data_b,
    output logic                gnt_b,
    output logic [DOT_ROWS-1:0] dot_row,
    output logic [DOT_COLS-1:0] dot_col,
    output logic                frame_start
);

    localparam int                 c_CNT_W   = $clog2(SCAN_DIV);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(SCAN_DIV - 1);

    if (SCAN_DIV < 4 || SCAN_DIV > (1 << 20) || BLANK_CYC < 0 || BLANK_CYC >= SCAN_DIV) begin : g_cfg_check
        $error("dot_scan_arbiter: illegal SCAN_DIV/BLANK_CYC combination");
    end

    logic [DOT_COLS-1:0] r_buf [DOT_ROWS];
    logic [c_CNT_W-1:0]  r_cnt;
    logic [ROW_W-1:0]    r_row_idx;
    logic [DOT_ROWS-1:0] r_dot_row;
    logic [DOT_COLS-1:0] r_dot_col;
    logic                r_frame_start;

    logic                w_sel;
    logic                w_wr;
    logic [ROW_W-1:0]    w_wr_row;
    logic [DOT_COLS-1:0] w_wr_data;
    logic                w_wrap;
    logic [ROW_W-1:0]    w_row_nxt;

    dot_rr_arb u_arb (
        .clk   (clk),
        .rst   (rst),
        .req_a (req_a),
        .req_b (req_b),
        .gnt_a (gnt_a),
        .gnt_b (gnt_b),
        .sel   (w_sel)
    );

    // The grant cycle is the commit cycle: the owner's row/data are still held.
    assign w_wr      = gnt_a | gnt_b;
    assign w_wr_row  = w_sel ? row_b  : row_a;
    assign w_wr_data = w_sel ? data_b : data_a;

    assign w_wrap    = (r_cnt == c_CNT_MAX);
    assign w_row_nxt = r_row_idx + 3'd1;   // 7 rolls over to 0

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DOT_ROWS; i++) begin
                r_buf[i] <= '0;
            end
            r_cnt         <= '0;
            r_row_idx     <= 3'd7;
            r_dot_row     <= '1;
            r_dot_col     <= '0;
            r_frame_start <= 1'b0;
        end else begin
            if (w_wr) begin
                r_buf[w_wr_row] <= w_wr_data;
            end

            r_frame_start <= 1'b0;
            if (w_wrap) begin
                r_cnt     <= '0;
                r_row_idx <= w_row_nxt;
                r_dot_row <= row_sel(w_row_nxt);
                // A commit landing on the row being loaded is forwarded so the
                // new data is not held back a whole frame.
                r_dot_col <= (w_wr && (w_wr_row == w_row_nxt)) ? w_wr_data
                                                               : r_buf[w_row_nxt];
                r_frame_start <= (w_row_nxt == 3'd0);
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

`ifdef DOT_BLANK_EN
    localparam logic [c_CNT_W-1:0] c_BLANK = c_CNT_W'(BLANK_CYC);

    // r_cnt restarts at 0 on every row load, so its low values mark the
    // start of the row period.
    logic w_blank;
    assign w_blank = (r_cnt < c_BLANK);
    assign dot_row = w_blank ? '1 : r_dot_row;
    assign dot_col = w_blank ? '0 : r_dot_col;
`else
    assign dot_row = r_dot_row;
    assign dot_col = r_dot_col;
`endif

    assign frame_start = r_frame_start;

endmodule
`default_nettype wire

// File: doc/dot_scan_arbiter.md
Name: dot_scan_arbiter

Overview:
- Owns the 8x16 LED frame buffer.
- Round-robin arbiter between two row-write requesters (A: button shift engine, B: pattern/auto-scroll loader); one write commits at a time.
- Row-scan sequencer drives the dot-matrix row/column pins from the buffer at a fixed row period.
- Sits between the pattern-generation logic and the board dot-matrix pins; replaces ad hoc per-module buffers.

Parameters:
- SCAN_DIV, 5000, clk cycles per displayed row (legal range 4..2^20).
- BLANK_CYC, 2, blanking cycles at the start of each row (used only with DOT_BLANK_EN; must be < SCAN_DIV).

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- req_a  in  1  requester A write request.
- row_a  in  3  requester A target row.
- data_a  in  16  requester A row data.
- gnt_a  out  1  grant/commit pulse to A.
- req_b  in  1  requester B write request.
- row_b  in  3  requester B target row.
- data_b  in  16  requester B row data.
- gnt_b  out  1  grant/commit pulse to B.
- dot_row  out  8  active-low one-hot row select.
- dot_col  out  16  active-high column drive.
- frame_start  out  1  one-cycle pulse when row 0 is loaded.

Behaviour:
- Reset (rst high at a clk edge): buffer all zero, row_idx=7, scan counter=0, rr pointer favours A, FSM=IDLE.
  - Outputs after reset: dot_row=8'hFF, dot_col=0, gnt_a=gnt_b=0, frame_start=0.
  - Reset mid-grant: gnt drops at that edge; the write is lost.
- Arbiter FSM states: IDLE, GNT_A, GNT_B.
  - IDLE, only req_a: go to GNT_A. Only req_b: go to GNT_B.
  - IDLE, both requests: grant the requester not granted last; after reset, A wins.
  - GNT_x: gnt_x=1 for exactly that cycle; buffer[row_x] <= data_x at the end of the cycle; rr pointer updates; next state is always IDLE.
  - Latency: req seen at cycle N, gnt at N+1. Throughput: at most one write per 2 cycles.
  - Requester rules: hold req, row and data stable until gnt; drop req the cycle after gnt, or it is re-arbitrated as a new request.
  - gnt_a and gnt_b are never high together.
- Scan counter:
  - Counts 0..SCAN_DIV-1 and wraps.
  - On wrap: row_idx <= row_idx+1 (mod 8, 7 wraps to 0); dot_row <= ~(8'h80 >> row_idx_next); dot_col <= buffer[row_idx_next].
  - The first row load occurs SCAN_DIV cycles after reset release, and it selects row 0.
- Row 0 mapping: dot_row=8'b01111111 (bit 7 low). Row 7: 8'b11111110.
- frame_start pulses for one cycle, coincident with the row-0 load.
- Write/scan collision: a commit to row r in the same cycle as the load of row r is bypassed, so dot_col shows data_x immediately.
- A write to the currently displayed row is not reflected until that row's next load; no mid-row update.

Optional Feature:
- Macro DOT_BLANK_EN.
- Defined: for the first BLANK_CYC cycles after each row load, dot_row=8'hFF and dot_col=0; the stored row values then drive the pins for the rest of the period. This suppresses ghosting.
  - frame_start timing is unchanged.
- Undefined: no blanking; outputs switch directly at row load, and BLANK_CYC is ignored.

Decomposition:
- Shared package dot_pkg holds:
  - DOT_ROWS=8, DOT_COLS=16;
  - the row-select encoding function (index to active-low one-hot);
  - the arbiter state enum {IDLE, GNT_A, GNT_B}.
- Sub-module dot_rr_arb: the two-way round-robin FSM. Inputs req_a, req_b; outputs gnt_a, gnt_b, sel.
- Buffer, scan counter and output registers stay in the top module.

Test Plan:
- Reset, then idle with SCAN_DIV=4:
  - dot_row=8'hFF during reset.
  - After release, row loads every 4 cycles in the order 8'h7F, 8'hBF, ... 8'hFE, 8'h7F.
  - dot_col=0 throughout; frame_start pulses every 32 cycles.
- Single write: req_a with row_a=3, data_a=16'h1C00 → gnt_a one cycle later.
  - On the next row-3 load, dot_row=8'hEF and dot_col=16'h1C00.
- Contention: req_a and req_b held high continuously, both dropped and re-raised after each grant → grants alternate A, B, A, B starting with A after reset, one grant every 2 cycles, never both high.
- Collision bypass: req_b with row_b=0, data_b=16'hFFFF timed so gnt_b coincides with the row-0 load → that same load shows dot_col=16'hFFFF.
- Reset mid-grant: assert rst in the GNT_A cycle → gnt_a low next cycle, buffer row unchanged (zero), outputs at reset values.
- DOT_BLANK_EN, SCAN_DIV=8, BLANK_CYC=2, row 1 = 16'hAAAA → after the row-1 load, 2 cycles of dot_row=8'hFF and dot_col=0, then 6 cycles of 8'hBF and 16'hAAAA.
